ifetch_buffer: RTL
==================

IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of prefetch FIFO entries and the limit on outstanding memory requests.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 PCF  in  32  fetch-stage PC requested by the pipeline.
REQ-006 StallF  in  1  pipeline holds PCF; the head entry is not consumed.
REQ-007 InstrF  out  32  instruction for PCF.
REQ-008 InstrValidF  out  1  InstrF is valid for the current PCF.
REQ-009 mem_req  out  1  instruction-memory read request.
REQ-010 mem_addr  out  32  word address of the request.
REQ-011 mem_gnt  in  1  request accepted this cycle.
REQ-012 mem_rvalid  in  1  read data returned this cycle; responses are in order.
REQ-013 mem_rdata  in  32  returned instruction word.

Function
REQ-014 FIFO entry SHALL hold {addr[31:0], instr[31:0]}; state is the FIFO count, inflight (granted, not returned), discard (oldest inflight to drop), next_addr, resp_addr.
REQ-015 expected_pc SHALL be head.addr when FIFO is non-empty, else resp_addr.
REQ-016 Hit (PCF == head.addr, FIFO non-empty) SHALL drive InstrValidF=1 and InstrF=head.instr combinationally in the same cycle.
REQ-017 No hit SHALL drive InstrValidF=0 and InstrF=32'h0000_0013 (NOP).
REQ-018 Hit with StallF=0 SHALL pop the head at the clock edge; a hit with StallF=1 SHALL NOT pop.
REQ-019 mem_req SHALL be 1 iff count + inflight < DEPTH, no redirect this cycle, and reset is deasserted; mem_addr = next_addr.
REQ-020 mem_req && mem_gnt SHALL increment inflight and advance next_addr by 4.
REQ-021 mem_rvalid SHALL decrement inflight; if discard > 0 it SHALL decrement discard and drop the data, else push {resp_addr, mem_rdata} and advance resp_addr by 4.
REQ-022 Pushed data SHALL be visible at the head no earlier than the cycle after mem_rvalid (no rvalid-to-InstrF bypass).
REQ-023 Redirect = PCF != expected_pc while discard == 0; redirect SHALL flush the FIFO, set next_addr and resp_addr to PCF, and set discard to inflight minus the response arriving in the same cycle.
REQ-024 Redirect while discard > 0 SHALL be evaluated against resp_addr once discard reaches 0; no new request issues until then if PCF != next_addr.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; the issue rule of REQ-019 SHALL make FIFO overflow impossible.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0.

Reset
REQ-027 While reset is low: FIFO empty, inflight = 0, discard = 0, next_addr = resp_addr = RESET_PC, mem_req = 0, InstrValidF = 0, InstrF = NOP.
REQ-028 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory side is reset by the same signal.
REQ-029 In the first cycle after reset release, mem_req SHALL be 1 with mem_addr = RESET_PC.

Structure
REQ-030 The NOP encoding, RESET_PC default and DEPTH default SHALL live in the shared cpu_pkg package.
REQ-031 Entry storage SHALL be one sub-module, fetch_fifo (push, pop, flush, count, head outputs).
REQ-032 Counters SHALL be sized $clog2(DEPTH+1) bits.

Verification
REQ-033 Scenario: reset release, mem_gnt = 1, 1-cycle rvalid, PCF stepping 0, 4, 8 -> mem_addr 0, 4, 8, ...; InstrValidF first high 2 cycles after the grant of address 0.
REQ-034 Scenario: StallF = 1 for 3 cycles with a full FIFO -> InstrF stable, mem_req = 0, count stays 4.
REQ-035 Scenario: PCF jumps to 32'h100 with 2 requests inflight -> FIFO flushed, 2 responses dropped, first kept entry has addr 32'h100.
REQ-036 Scenario: redirect in the same cycle as mem_rvalid -> discard = inflight-1, the arriving word is not pushed.
REQ-037 Scenario: mem_gnt held 0 for 5 cycles -> mem_req stays 1, mem_addr stays constant, InstrValidF = 0 with InstrF = 32'h0000_0013.
REQ-038 Scenario: reset asserted with 3 requests inflight, then released -> all counters 0, next request at RESET_PC, no stale data reaches InstrF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the prefetch entry type used by the fetch front end.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned DEPTH_DEFAULT    = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential fetch step; wraps modulo 2^32.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer and memory.
interface ifetch_buffer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch store of {addr, instr} entries with flush.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; flush overrides push/pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_buffer.sv
// Prefetching instruction fetch buffer: issues sequential reads, buffers in-order
// responses, serves the pipeline PC on a head hit and redirects on a PC mismatch.
module ifetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           PCF,
    input  logic                  StallF,
    output logic [31:0]           InstrF,
    output logic                  InstrValidF,
    ifetch_buffer_if.master       mem
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   next_addr_q, next_addr_d;
    logic [31:0]   resp_addr_q, resp_addr_d;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          push, pop, flush;

    logic [CW:0]   occupancy;
    logic          non_empty, hit, redirect, hold, gnt_fire;
    logic [31:0]   expected_pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head       (head)
    );

    // Hit/redirect decisions, issue rule and next-state of the request tracking.
    // Responses still owed to an abandoned stream are dropped before any redirect
    // is re-evaluated; meanwhile issue continues only along the current target.
    always_comb begin
        occupancy   = {1'b0, count} + {1'b0, inflight_q};
        non_empty   = (count != '0);
        expected_pc = non_empty ? head.addr : resp_addr_q;
        hit         = non_empty && (PCF == head.addr);
        redirect    = (discard_q == '0) && (PCF != expected_pc);
        hold        = (discard_q != '0) && (PCF != next_addr_q);

        mem.mem_req  = reset && (occupancy < (CW + 1)'(DEPTH)) && !redirect && !hold;
        mem.mem_addr = next_addr_q;
        gnt_fire     = mem.mem_req && mem.mem_gnt;

        InstrValidF = hit;
        InstrF      = hit ? head.instr : NOP_INSTR;

        push_entry  = '{addr: resp_addr_q, instr: mem.mem_rdata};
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        next_addr_d = next_addr_q;
        resp_addr_d = resp_addr_q;
        discard_d   = discard_q;
        inflight_d  = inflight_q + CW'(gnt_fire) - CW'(mem.mem_rvalid);

        if (redirect) begin
            flush       = 1'b1;
            next_addr_d = PCF;
            resp_addr_d = PCF;
            discard_d   = inflight_q - CW'(mem.mem_rvalid);
        end else begin
            pop = hit && !StallF;
            if (gnt_fire) begin
                next_addr_d = pc_step(next_addr_q);
            end
            if (mem.mem_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push        = 1'b1;
                    resp_addr_d = pc_step(resp_addr_q);
                end
            end
        end
    end

    // Request-tracking registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q  <= '0;
            discard_q   <= '0;
            next_addr_q <= RESET_PC;
            resp_addr_q <= RESET_PC;
        end else begin
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            next_addr_q <= next_addr_d;
            resp_addr_q <= resp_addr_d;
        end
    end

endmodule
